// File: rtl/scr1_sp_memory.sv
// -----------------------------------------------------------------------------
// scr1_sp_memory
//
// Purpose:
//   Single-port synchronous RAM with per-byte write enables and one clock.
//   It is the backing store for the TCM block, where the TCM arbiter
//   multiplexes imem/dmem onto port A. Read data is registered, so it
//   appears one cycle after the request. The storage array is named
//   ram_block so that benches can preload it hierarchically through
//   <inst>.ram_block.
//
// Configuration macro:
//   SCR1_SP_MEMORY_READ_FIRST_EN
//     defined   : rena=1 and wena=1 in the same cycle returns the word as it
//                 was before the write (read-first).
//     undefined : rena=1 and wena=1 in the same cycle leaves qa unchanged
//                 (the write has priority and no read is done).
//   The write behaves the same in both builds.
//
// Ports:
//   clk    in   1           clock; all state updates on posedge
//   rst    in   1           asynchronous active-high reset (clears qa, blocks writes)
//   rena   in   1           read enable
//   wena   in   1           write enable
//   weba   in   NB          byte write enables; bit i selects dataa[8i+7:8i]
//   addra  in   AW          word address
//   dataa  in   SCR1_WIDTH  write data
//   qa     out  SCR1_WIDTH  registered read data
// -----------------------------------------------------------------------------
module scr1_sp_memory #(
    parameter int SCR1_WIDTH = 32,
    parameter int SCR1_SIZE  = 'h00010000,
    localparam int NB        = SCR1_WIDTH / 8,
    localparam int AW        = $clog2(SCR1_SIZE / NB)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rena,
    input  logic                  wena,
    input  logic [NB-1:0]         weba,
    input  logic [AW-1:0]         addra,
    input  logic [SCR1_WIDTH-1:0] dataa,
    output logic [SCR1_WIDTH-1:0] qa
);

    localparam int DEPTH = SCR1_SIZE / NB;

    // Storage is deliberately not reset; contents stay X until they are
    // written or preloaded.
    logic [SCR1_WIDTH-1:0] ram_block [0:DEPTH-1];

    // Byte-lane write. The rst check is sampled on the clock edge so that the
    // array can still map onto a plain synchronous RAM macro.
    always_ff @(posedge clk) begin
        if (!rst && wena) begin
            for (int i = 0; i < NB; i++) begin
                if (weba[i]) begin
                    ram_block[addra][8*i +: 8] <= dataa[8*i +: 8];
                end
            end
        end
    end

    // Registered read port. The non-blocking write above has not yet landed
    // when ram_block is sampled here, so a read in the same cycle as a write
    // sees the pre-write contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            qa <= '0;
        end else if (rena) begin
`ifdef SCR1_SP_MEMORY_READ_FIRST_EN
            qa <= ram_block[addra];
`else
            if (!wena) begin
                qa <= ram_block[addra];
            end
`endif
        end
    end

endmodule

// File: tb/tb_scr1_sp_memory.sv
module tb_scr1_sp_memory;

    localparam int W  = 32;
    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rena = 1'b0;
    logic          wena = 1'b0;
    logic [3:0]    weba = '0;
    logic [AW-1:0] addra = '0;
    logic [W-1:0]  dataa = '0;
    logic [W-1:0]  qa;

    scr1_sp_memory #(.SCR1_WIDTH(W), .SCR1_SIZE('h00010000)) dut (
        .clk   (clk),
        .rst   (rst),
        .rena  (rena),
        .wena  (wena),
        .weba  (weba),
        .addra (addra),
        .dataa (dataa),
        .qa    (qa)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Behavioural model: a sparse word memory plus the expected qa value.
    logic [W-1:0] mem [int];
    logic [W-1:0] exp_qa = '0;
    bit           exp_valid = 1'b0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req)
            $display("FAIL %s: qa=%h expected=%h at %0t", name, act, req, $time);
        else
            passed++;
    endtask

    function automatic logic [W-1:0] model_read(input int a);
        if (mem.exists(a)) return mem[a];
        return 'x;
    endfunction

    // One clock of stimulus; the model is advanced from the same request.
    task automatic op(input logic r, input logic w, input logic [3:0] be,
                      input logic [AW-1:0] a, input logic [W-1:0] d);
        logic [W-1:0] old;
        rena = r; wena = w; weba = be; addra = a; dataa = d;
        @(posedge clk);
        if (!rst) begin
            old = model_read(int'(a));
            if (r) begin
`ifdef SCR1_SP_MEMORY_READ_FIRST_EN
                exp_qa = old;
`else
                if (!w) exp_qa = old;
`endif
                exp_valid = !$isunknown(exp_qa);
            end
            if (w) begin
                for (int i = 0; i < 4; i++)
                    if (be[i]) old[8*i +: 8] = d[8*i +: 8];
                mem[int'(a)] = old;
            end
        end
        #1;
    endtask

    task automatic idle();
        op(1'b0, 1'b0, 4'h0, '0, '0);
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (exp_valid) check("qa_model", qa, exp_qa);
    end

    logic [W-1:0] pre_tab [4];
    logic [W-1:0] held;

    initial begin
        pre_tab[0] = 32'h0BADF00D;
        pre_tab[1] = 32'h13579BDF;
        pre_tab[2] = 32'h2468ACE0;
        pre_tab[3] = 32'hFEDCBA98;

        // Reset is active from time zero; once an edge has passed, qa must be 0.
        @(posedge clk); #1;
        exp_qa = '0; exp_valid = 1'b1;
        check("reset_qa", qa, 32'h0);
        @(posedge clk); #2;
        rst = 1'b0;

        // Full-word write then read.
        op(1'b0, 1'b1, 4'hF, 14'd5, 32'hDEADBEEF);
        op(1'b1, 1'b0, 4'h0, 14'd5, '0);
        check("full_word", qa, 32'hDEADBEEF);

        // Single byte-lane update.
        op(1'b0, 1'b1, 4'b0010, 14'd5, 32'h00005A00);
        op(1'b1, 1'b0, 4'h0, 14'd5, '0);
        check("byte_lane1", qa, 32'hDEAD5AEF);

        // Mixed lanes on another address.
        op(1'b0, 1'b1, 4'hF, 14'd9, 32'h01020304);
        op(1'b0, 1'b1, 4'b1001, 14'd9, 32'hA0B0C0D0);
        op(1'b1, 1'b0, 4'h0, 14'd9, '0);
        check("byte_lane_03", qa, 32'hA00203D0);

        // Back-to-back reads at both ends of the address range, then hold.
        op(1'b0, 1'b1, 4'hF, 14'd0, 32'h11111111);
        op(1'b0, 1'b1, 4'hF, 14'h3FFF, 32'h22222222);
        op(1'b1, 1'b0, 4'h0, 14'd0, '0);
        check("read_addr0", qa, 32'h11111111);
        op(1'b1, 1'b0, 4'h0, 14'h3FFF, '0);
        check("read_top", qa, 32'h22222222);
        idle(); idle(); idle();
        check("hold", qa, 32'h22222222);

        // Read after write in the next cycle.
        op(1'b0, 1'b1, 4'hF, 14'd12, 32'hCAFEF00D);
        op(1'b1, 1'b0, 4'h0, 14'd12, '0);
        check("raw_next", qa, 32'hCAFEF00D);

        // Simultaneous read and write.
        op(1'b0, 1'b1, 4'hF, 14'd7, 32'hAAAA5555);
        op(1'b1, 1'b0, 4'h0, 14'd0, '0);
        check("pre_collide", qa, 32'h11111111);
        op(1'b1, 1'b1, 4'hF, 14'd7, 32'h12345678);
`ifdef SCR1_SP_MEMORY_READ_FIRST_EN
        check("collide_qa", qa, 32'hAAAA5555);
`else
        check("collide_qa", qa, 32'h11111111);
`endif
        op(1'b1, 1'b0, 4'h0, 14'd7, '0);
        check("collide_wr", qa, 32'h12345678);

        // A write with no byte enables changes nothing.
        op(1'b0, 1'b1, 4'h0, 14'd7, 32'hFFFFFFFF);
        op(1'b1, 1'b0, 4'h0, 14'd7, '0);
        check("noop_write", qa, 32'h12345678);

        // Asynchronous reset mid-run while qa is nonzero; a write under reset is blocked.
        #2;
        rst = 1'b1;
        #1;
        exp_qa = '0;
        check("async_reset", qa, 32'h0);
        op(1'b1, 1'b1, 4'hF, 14'd7, 32'h0);
        check("reset_hold", qa, 32'h0);
        #1;
        rst = 1'b0;
        idle(); idle();
        check("post_reset_idle", qa, 32'h0);
        op(1'b1, 1'b0, 4'h0, 14'd7, '0);
        check("reset_blocked_wr", qa, 32'h12345678);

        // Fill words 0..3, then read them back in order.
        for (int i = 0; i < 4; i++) op(1'b0, 1'b1, 4'hF, AW'(i), pre_tab[i]);
        for (int i = 0; i < 4; i++) begin
            op(1'b1, 1'b0, 4'h0, AW'(i), '0);
            check("fill_read", qa, pre_tab[i]);
        end

        // A held value survives requests that only drive the address.
        held = qa;
        op(1'b0, 1'b0, 4'h0, 14'd5, '0);
        check("hold_addr_change", qa, 32'hFEDCBA98);
        op(1'b1, 1'b0, 4'h0, 14'd5, '0);
        check("final_read5", qa, 32'hDEAD5AEF);
        if (held !== 32'hFEDCBA98) check("held_snapshot", held, 32'hFEDCBA98);

        idle();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    // Safety bound so the run always terminates.
    initial begin
        #100000;
        checks++;
        $display("FAIL timeout: simulation exceeded time budget");
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
